// File: rtl/call_return_stack_pkg.sv
// Shared definitions for the call/return stack.
//   PC_WIDTH      : program-counter width, default entry width of the stack
//   stack_op_e    : effective operation after push/pop/empty/full resolution
//   decode_op()   : maps raw push/pop requests to the operation actually performed
package call_return_stack_pkg;

  localparam int unsigned PC_WIDTH = 12;

  typedef enum logic [1:0] {
    OpNone,
    OpPush,
    OpPop,
    OpReplace
  } stack_op_e;

  // Push to a full stack and pop from an empty stack are dropped. Push+pop
  // replaces the top, except on an empty stack where it degenerates to a push.
  function automatic stack_op_e decode_op(input logic push, input logic pop,
                                          input logic empty, input logic full);
    stack_op_e op;
    op = OpNone;
    if (push && pop) begin
      op = empty ? OpPush : OpReplace;
    end else if (push) begin
      op = full ? OpNone : OpPush;
    end else if (pop) begin
      op = empty ? OpNone : OpPop;
    end
    return op;
  endfunction

endpackage

// File: rtl/call_return_stack.sv
// LIFO of return addresses for the program-counter controller.
// Ports:
//   clk       : system clock, all state changes on the rising edge
//   reset     : synchronous active-high reset (clears occupancy only)
//   push      : store writedata as the new top at the next edge
//   pop       : discard the current top at the next edge
//   writedata : value to push
//   readdata  : current top of stack, zero when empty
//   empty     : occupancy == 0
//   full      : occupancy == DEPTH
module call_return_stack
  import call_return_stack_pkg::*;
#(
  parameter int unsigned WIDTH = PC_WIDTH,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PTR_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] readdata,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] count_q, count_d;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_addr;
  logic             wr_en;
  stack_op_e        op;

  assign empty   = (count_q == '0);
  assign full    = (count_q == PTR_W'(DEPTH));
  // Only meaningful when not empty; readdata masks the empty case.
  assign top_idx = AW'(count_q - PTR_W'(1));
  assign readdata = empty ? '0 : mem_q[top_idx];

  always_comb begin
    op      = decode_op(push, pop, empty, full);
    count_d = count_q;
    wr_en   = 1'b0;
    wr_addr = AW'(count_q);
    unique case (op)
      OpPush: begin
        wr_en   = 1'b1;
        count_d = count_q + PTR_W'(1);
      end
      OpPop: begin
        count_d = count_q - PTR_W'(1);
      end
      OpReplace: begin
        wr_en   = 1'b1;
        wr_addr = top_idx;
      end
      default: ;
    endcase
    if (reset) begin
      count_d = '0;
      wr_en   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  // Storage is deliberately not reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= writedata;
    end
  end

endmodule

// File: tb/tb_call_return_stack.sv
module tb_call_return_stack;

  localparam int W = 12;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         push = 1'b0;
  logic         pop = 1'b0;
  logic [W-1:0] writedata = '0;
  logic [W-1:0] readdata;
  logic         empty;
  logic         full;

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;

  // Reference: a plain queue, back() is the top of stack.
  logic [W-1:0] mdl[$];

  call_return_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .writedata(writedata),
    .readdata (readdata),
    .empty    (empty),
    .full     (full)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] exp_top();
    if (mdl.size() == 0) return '0;
    return mdl[mdl.size()-1];
  endfunction

  task automatic model_step(input bit r, input bit pu, input bit po, input logic [W-1:0] d);
    if (r) begin
      mdl.delete();
    end else if (pu && po) begin
      if (mdl.size() == 0) mdl.push_back(d);
      else mdl[mdl.size()-1] = d;
    end else if (pu) begin
      if (mdl.size() < D) mdl.push_back(d);
    end else if (po) begin
      if (mdl.size() > 0) void'(mdl.pop_back());
    end
  endtask

  task automatic apply(input bit r, input bit pu, input bit po, input logic [W-1:0] d);
    reset = r;
    push = pu;
    pop = po;
    writedata = d;
    @(posedge clk);
    model_step(r, pu, po, d);
    if (r) started = 1'b1;
    vectors++;
    #1;
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
      miscompares++;
    end
  endtask

  // Every-cycle check against the queue model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      if (readdata !== exp_top() || empty !== (mdl.size() == 0) ||
          full !== (mdl.size() == D)) begin
        $display("FAIL cycle_check t=%0t: actual rd=0x%0h e=%0b f=%0b required rd=0x%0h e=%0b f=%0b",
                 $time, readdata, empty, full, exp_top(), (mdl.size() == 0), (mdl.size() == D));
        miscompares++;
      end
    end
  end

  initial begin
    int pu_pct;
    // Reset and pop-while-empty
    apply(1, 0, 0, '0);
    lit("rst_empty", 32'(empty), 1);
    lit("rst_full", 32'(full), 0);
    lit("rst_rd", 32'(readdata), 0);
    apply(0, 0, 1, '0);
    lit("pop_empty_rd", 32'(readdata), 0);
    lit("pop_empty_e", 32'(empty), 1);

    // Three pushes then three pops
    apply(0, 1, 0, 12'h005);
    lit("push1", 32'(readdata), 32'h005);
    apply(0, 1, 0, 12'h123);
    lit("push2", 32'(readdata), 32'h123);
    apply(0, 1, 0, 12'hABC);
    lit("push3", 32'(readdata), 32'hABC);
    lit("push3_e", 32'(empty), 0);
    apply(0, 0, 1, '0);
    lit("pop1", 32'(readdata), 32'h123);
    apply(0, 0, 1, '0);
    lit("pop2", 32'(readdata), 32'h005);
    apply(0, 0, 1, '0);
    lit("pop3", 32'(readdata), 32'h000);
    lit("pop3_e", 32'(empty), 1);

    // Fill, overflow attempt, one pop
    for (int i = 0; i < 16; i++) apply(0, 1, 0, 12'(12'h100 + i));
    lit("fill_full", 32'(full), 1);
    lit("fill_rd", 32'(readdata), 32'h10F);
    apply(0, 1, 0, 12'hFFF);
    lit("ovf_rd", 32'(readdata), 32'h10F);
    lit("ovf_full", 32'(full), 1);
    apply(0, 0, 1, '0);
    lit("unfill_full", 32'(full), 0);
    lit("unfill_rd", 32'(readdata), 32'h10E);

    // Simultaneous push+pop
    apply(1, 0, 0, '0);
    apply(0, 1, 0, 12'h0AA);
    apply(0, 1, 1, 12'h0BB);
    lit("replace_rd", 32'(readdata), 32'h0BB);
    apply(0, 0, 1, '0);
    lit("replace_cnt", 32'(empty), 1);
    apply(0, 1, 1, 12'h077);
    lit("pp_empty_rd", 32'(readdata), 32'h077);
    lit("pp_empty_e", 32'(empty), 0);

    // Mid-operation reset with push asserted
    apply(1, 0, 0, '0);
    for (int i = 0; i < 5; i++) apply(0, 1, 0, 12'(12'h200 + i));
    apply(1, 1, 0, 12'h333);
    lit("midrst_e", 32'(empty), 1);
    lit("midrst_rd", 32'(readdata), 0);
    apply(0, 1, 0, 12'h042);
    lit("post_rst_push", 32'(readdata), 32'h042);

    // Randomized phases with varying push bias so both ends are exercised
    pu_pct = 50;
    for (int n = 0; n < 3000; n++) begin
      int rnd;
      bit r, pu, po;
      if (n % 100 == 0) pu_pct = $urandom_range(15, 85);
      rnd = $urandom_range(0, 99);
      r = ($urandom_range(0, 299) == 0);
      pu = (rnd < pu_pct);
      po = ($urandom_range(0, 99) >= pu_pct) || ($urandom_range(0, 9) == 0);
      apply(r, pu, po, 12'($urandom));
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
